// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller.
// Holds the fill state enum and the block geometry constants.
package cache_fill_fsm_pkg;

  localparam int unsigned BLOCK_BYTES     = 16;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned OFFSET_BITS     = 4;
  localparam int unsigned CNT_W           = 3;
  localparam int unsigned WORD_W          = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Small up-counter used to track issued and received words of a fill.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : increment by one
//   count      : current value
//   tc         : terminal count, high when count is all ones
module cache_fill_fsm_word_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = &count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss, latches the block base, issues
// the eight word reads of the block on consecutive cycles, streams the
// returned words into the data array and writes the tag on the last word.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   miss_detected, miss_address   : miss request from the cache lookup
//   fsm_busy                      : fill in progress (stalls requester)
//   mem_rd_en, memory_address     : read request to main memory
//   memory_data_valid, memory_data: returned word from memory
//   write_data_array, cache_word_addr, cache_word_data : data array write
//   write_tag_array               : tag/valid write for the block
//   fill_done                     : pulse on the final word
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned MEM_LAT     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] memory_address,
  input  logic              memory_data_valid,
  input  logic [WORD_W-1:0] memory_data,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_word_addr,
  output logic [WORD_W-1:0] cache_word_data,
  output logic              write_tag_array,
  output logic              fill_done
);

  localparam int unsigned BASE_W = ADDR_W - OFFSET_BITS;

  // Guard against parameterisations the fixed 3-bit counters cannot serve.
  if (BLOCK_WORDS != WORDS_PER_BLOCK) begin : g_bad_block_words
    $error("cache_fill_fsm: BLOCK_WORDS must equal WORDS_PER_BLOCK");
  end
  if (MEM_LAT == 0) begin : g_bad_mem_lat
    $error("cache_fill_fsm: MEM_LAT must be at least 1");
  end

  fill_state_e       state_q, state_d;
  logic [BASE_W-1:0] base_hi_q;
  logic              issue_done_q, issue_done_d;
  logic              load_base;

  logic              issue_clr, issue_en, issue_tc;
  logic              recv_clr, recv_en, recv_tc;
  logic [CNT_W-1:0]  issue_cnt, recv_cnt;

  cache_fill_fsm_word_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (issue_clr),
    .en    (issue_en),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  cache_fill_fsm_word_counter #(.W(CNT_W)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (recv_clr),
    .en    (recv_en),
    .count (recv_cnt),
    .tc    (recv_tc)
  );

  // State, block base and issue-complete flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_hi_q    <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_done_q <= issue_done_d;
      if (load_base) begin
        base_hi_q <= miss_address[ADDR_W-1:OFFSET_BITS];
      end
    end
  end

  // Next state and outputs. The base is block aligned, so base + 2*cnt is
  // a plain concatenation: the word offset can never carry into the tag.
  always_comb begin
    state_d          = state_q;
    issue_done_d     = issue_done_q;
    load_base        = 1'b0;
    issue_clr        = 1'b0;
    issue_en         = 1'b0;
    recv_clr         = 1'b0;
    recv_en          = 1'b0;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_word_addr  = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          load_base    = 1'b1;
          issue_clr    = 1'b1;
          recv_clr     = 1'b1;
          issue_done_d = 1'b0;
          state_d      = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        // Issue side: counter saturates on the last word, flag stops issue.
        if (!issue_done_q) begin
          mem_rd_en      = 1'b1;
          memory_address = {base_hi_q, issue_cnt, 1'b0};
          issue_en       = !issue_tc;
          issue_done_d   = issue_tc;
        end

        // Receive side: advances only on a returned word.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          cache_word_addr  = {base_hi_q, recv_cnt, 1'b0};
          recv_en          = 1'b1;
          if (recv_tc) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cache_word_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_rd_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [15:0] cache_word_addr;
  logic [15:0] cache_word_data;
  logic        write_tag_array;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(16), .BLOCK_WORDS(8), .MEM_LAT(LAT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_rd_en         (mem_rd_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .cache_word_addr   (cache_word_addr),
    .cache_word_data   (cache_word_data),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_seen = 0;
  logic [15:0] seed = 16'h0000;

  // Pipelined memory: each request returns LAT cycles later, in order.
  typedef struct {
    int          due;
    logic [15:0] addr;
  } req_t;
  req_t pend[$];

  // Behavioural reference: a fill is "busy, base, words issued, words received".
  bit          m_busy = 1'b0;
  logic [15:0] m_base = 16'h0;
  int          m_issued = 0;
  int          m_recv = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (seed == 16'h0) return 16'hA000 + 16'((a >> 1) & 16'h7);
    return a ^ seed ^ {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 16'(fsm_busy), 16'h0);
    chk({tag, ".rd"}, 16'(mem_rd_en), 16'h0);
    chk({tag, ".maddr"}, memory_address, 16'h0);
    chk({tag, ".wr"}, 16'(write_data_array), 16'h0);
    chk({tag, ".waddr"}, cache_word_addr, 16'h0);
    chk({tag, ".wdata"}, cache_word_data, 16'h0);
    chk({tag, ".tag"}, 16'(write_tag_array), 16'h0);
    chk({tag, ".done"}, 16'(fill_done), 16'h0);
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance models.
  task automatic step(input logic miss, input logic [15:0] maddr, input bit hold, input bit stray);
    bit          exp_rd, exp_wr, exp_last, popped;
    logic [15:0] exp_ma, exp_wa;
    popped = 1'b0;
    miss_detected = miss;
    miss_address  = maddr;
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_word(pend[0].addr);
      popped            = 1'b1;
    end else if (stray) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
    #1;
    exp_rd   = m_busy && (m_issued < 8);
    exp_ma   = exp_rd ? m_base + 16'(2 * m_issued) : 16'h0;
    exp_wr   = m_busy && memory_data_valid;
    exp_wa   = exp_wr ? m_base + 16'(2 * m_recv) : 16'h0;
    exp_last = exp_wr && (m_recv == 7);
    chk("busy", 16'(fsm_busy), 16'(m_busy));
    chk("mem_rd_en", 16'(mem_rd_en), 16'(exp_rd));
    chk("memory_address", memory_address, exp_ma);
    chk("write_data_array", 16'(write_data_array), 16'(exp_wr));
    chk("cache_word_addr", cache_word_addr, exp_wa);
    if (exp_wr) chk("cache_word_data", cache_word_data, mem_word(m_base + 16'(2 * m_recv)));
    chk("write_tag_array", 16'(write_tag_array), 16'(exp_last));
    chk("fill_done", 16'(fill_done), 16'(exp_last));
    if (fsm_busy === 1'b1) busy_seen++;

    if (popped) void'(pend.pop_front());
    if (exp_rd) pend.push_back('{due: cyc + LAT, addr: exp_ma});
    if (!m_busy) begin
      if (miss) begin
        m_busy   = 1'b1;
        m_base   = maddr & 16'hFFF0;
        m_issued = 0;
        m_recv   = 0;
      end
    end else begin
      if (m_issued < 8) m_issued++;
      if (memory_data_valid) begin
        m_recv++;
        if (m_recv == 8) m_busy = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Accept a miss, then run the fill to completion with an optional gap in
  // returned data and an optional ignored miss at cycle miss_k.
  task automatic run_fill(input logic [15:0] addr, input int gap_after, input int gap_len,
                          input int miss_k, input logic [15:0] addr2, input int exp_busy);
    int k;
    int gaps;
    bit hold;
    k = 0;
    gaps = 0;
    busy_seen = 0;
    step(1'b1, addr, 1'b0, 1'b0);
    while (m_busy && k < 100) begin
      hold = (m_recv == gap_after) && (gaps < gap_len);
      if (hold) gaps++;
      step(k == miss_k, (k == miss_k) ? addr2 : 16'h0, hold, 1'b0);
      k++;
    end
    if (m_busy) begin
      checks++;
      errors++;
      $error("FAIL fill_timeout: fill of %h still busy after %0d cycles", addr, k);
      m_busy = 1'b0;
    end
    if (exp_busy > 0) chk("busy_cycles", 16'(busy_seen), 16'(exp_busy));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a miss pending: everything must stay 0.
    rst_n = 1'b0;
    miss_detected = 1'b1;
    miss_address = 16'h1236;
    memory_data_valid = 1'b0;
    memory_data = 16'h0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset_hold");
    rst_n = 1'b1;

    // First edge after release takes the held miss; gapless 12-cycle fill.
    run_fill(16'h1236, 99, 0, -1, 16'h0, 12);

    // Back-to-back: miss in the first IDLE cycle, valid gap after word 5,
    // and a different miss at k=5 which must be ignored.
    run_fill(16'h2468, 5, 3, 5, 16'h9ABC, 15);

    // Top of address space.
    run_fill(16'hFFFE, 99, 0, -1, 16'h0, 12);

    // Idle cycles with stray valids must not write anything.
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-fill at k=6.
    step(1'b1, 16'h4566, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre_abort_busy", 16'(fsm_busy), 16'h1);
    #2;
    rst_n = 1'b0;
    memory_data_valid = 1'b0;
    memory_data = 16'h0;
    #1;
    chk_zero("abort");
    pend.delete();
    m_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
    run_fill(16'h4566, 99, 0, -1, 16'h0, 12);

    // Randomized fills with gaps, ignored misses and idle spacing.
    for (int n = 0; n < 20; n++) begin
      int g, gl, mk, idle;
      seed = 16'($urandom_range(1, 16'hFFFF));
      g    = $urandom_range(1, 7);
      gl   = $urandom_range(0, 4);
      mk   = $urandom_range(0, 11);
      idle = $urandom_range(0, 3);
      run_fill(16'($urandom), g, gl, mk, 16'($urandom), 12 + gl);
      for (int i = 0; i < idle; i++) step(1'b0, 16'($urandom), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
